// File: rtl/vga_rect_mover.sv
// Once-per-frame rectangle animator for the VGA pixel/colour stage.
// Optional colour cycling on wall hits: RECT_MOVER_COLOR_CYCLE_EN.
module vga_rect_mover #(
  parameter logic [9:0] H_VALID    = 10'd640,
  parameter logic [9:0] V_VALID    = 10'd480,
  parameter logic [9:0] RECT_W     = 10'd256,
  parameter logic [9:0] RECT_H     = 10'd64,
  parameter logic [9:0] INIT_X     = 10'd192,
  parameter logic [9:0] INIT_Y     = 10'd208,
  parameter logic [3:0] INIT_COLOR = 4'd0
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       run,
  input  logic [3:0] step_x,
  input  logic [3:0] step_y,
  output logic [9:0] char_x_start,
  output logic [9:0] char_x_end,
  output logic [9:0] char_y_start,
  output logic [9:0] char_y_end,
  output logic [3:0] char_color,
  output logic       frame_done,
  output logic       bounce
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    MOVE,
    COMMIT
  } state_t;

  localparam logic [10:0] X_MAX =
    {1'b0, H_VALID} - {1'b0, RECT_W};
  localparam logic [10:0] Y_MAX =
    {1'b0, V_VALID} - {1'b0, RECT_H};

  state_t     state;
  logic       fe_lvl;
  logic       fe_lvl_q;
  logic       fe;
  logic       dx_neg;
  logic       dy_neg;
  logic [9:0] x_sh;
  logic [9:0] y_sh;
  logic       dx_sh;
  logic       dy_sh;
  logic       hit_sh;
  logic [11:0] ax;
  logic [11:0] ay;

  // Returns {hit, new_dir_neg, new_pos}; math is 11 bits wide.
  function automatic logic [11:0] axis_next(
    input logic [9:0]  pos,
    input logic        neg,
    input logic [3:0]  step,
    input logic [10:0] lim
  );
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] sum;
    logic [10:0] dif;
    logic [11:0] r;
    p   = {1'b0, pos};
    s   = {7'd0, step};
    sum = p + s;
    dif = p - s;
    if (step == 4'd0) begin
      r = {1'b0, neg, pos};
    end else if (!neg) begin
      if (sum >= lim) r = {1'b1, 1'b1, lim[9:0]};
      else            r = {1'b0, 1'b0, sum[9:0]};
    end else begin
      if (p <= s) r = {1'b1, 1'b0, 10'd0};
      else        r = {1'b0, 1'b1, dif[9:0]};
    end
    return r;
  endfunction

  assign fe_lvl = (pix_x == H_VALID - 10'd1) &&
                  (pix_y == V_VALID - 10'd1);
  assign fe     = fe_lvl && !fe_lvl_q;

  assign ax = axis_next(char_x_start, dx_neg,
                        step_x, X_MAX);
  assign ay = axis_next(char_y_start, dy_neg,
                        step_y, Y_MAX);

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      fe_lvl_q     <= 1'b0;
      char_x_start <= INIT_X;
      char_x_end   <= INIT_X + RECT_W;
      char_y_start <= INIT_Y;
      char_y_end   <= INIT_Y + RECT_H;
      dx_neg       <= 1'b0;
      dy_neg       <= 1'b0;
      x_sh         <= INIT_X;
      y_sh         <= INIT_Y;
      dx_sh        <= 1'b0;
      dy_sh        <= 1'b0;
      hit_sh       <= 1'b0;
      frame_done   <= 1'b0;
      bounce       <= 1'b0;
    end else begin
      fe_lvl_q   <= fe_lvl;
      frame_done <= 1'b0;
      bounce     <= 1'b0;
      unique case (state)
        IDLE: if (run) state <= WAIT;
        WAIT: begin
          if (!run)    state <= IDLE;
          else if (fe) state <= MOVE;
        end
        MOVE: begin
          x_sh   <= ax[9:0];
          dx_sh  <= ax[10];
          y_sh   <= ay[9:0];
          dy_sh  <= ay[10];
          hit_sh <= ax[11] | ay[11];
          state  <= COMMIT;
        end
        COMMIT: begin
          char_x_start <= x_sh;
          char_x_end   <= x_sh + RECT_W;
          char_y_start <= y_sh;
          char_y_end   <= y_sh + RECT_H;
          dx_neg       <= dx_sh;
          dy_neg       <= dy_sh;
          frame_done   <= 1'b1;
          bounce       <= hit_sh;
          state        <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECT_MOVER_COLOR_CYCLE_EN
  logic [3:0] col_sh;

  // BLACK (7) is the background colour, so it is never shown.
  function automatic logic [3:0] col_next(
    input logic [3:0] c
  );
    logic [3:0] r;
    if (c == 4'd6)       r = 4'd8;
    else if (c >= 4'd9)  r = 4'd0;
    else                 r = c + 4'd1;
    return r;
  endfunction

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      char_color <= INIT_COLOR;
      col_sh     <= INIT_COLOR;
    end else begin
      if (state == MOVE) begin
        col_sh <= (ax[11] | ay[11]) ?
                  col_next(char_color) : char_color;
      end
      if (state == COMMIT) char_color <= col_sh;
    end
  end
`else
  assign char_color = INIT_COLOR;
`endif

endmodule
